olimp_pcpi_vmac: RTL and testbench
==================================

# olimp_pcpi_vmac

Parametrised PCPI coprocessor that runs vector multiply-accumulate for the OLIMP soft-SoC. It decodes custom RV32 instructions and drives data/coef memory addresses itself. It computes per-channel uint8×int8 dot products through a registered pipeline and keeps saturating per-channel accumulators, with bias-load, ReLU readout and clear operations. It sits between the picorv32 PCPI port and the data/coef RAMs, in place of the in-SoC inline MAC logic.

## Interface
- LANES, 8: bytes per data word; data bus width is LANES*8.
- CHANNELS, 2: output channels; coef bus width is CHANNELS*LANES*8.
- ACC_W, 32: accumulator width. Legal range is 20..32.
- DATA_AW, 17: data address width.
- COEF_AW, 15: coef address width.
- RD_LAT, 1: memory read latency in cycles. Must be ≥1.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pcpi_valid  in  1  CPU request.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  32  operand 1.
- pcpi_rs2  in  32  operand 2.
- pcpi_wr  out  1  rd write enable. Qualified by pcpi_ready.
- pcpi_rd  out  32  result.
- pcpi_wait  out  1  busy indication to the CPU.
- pcpi_ready  out  1  one-cycle completion pulse.
- mem_busy  out  1  high in FETCH. The SoC muxes data_addr/coef_addr onto the RAMs while this is high.
- data_addr  out  DATA_AW  data RAM address, equal to rs1[DATA_AW-1:0].
- coef_addr  out  COEF_AW  coef RAM address, equal to rs2[COEF_AW-1:0].
- data_rdata  in  LANES*8  data RAM read word.
- coef_rdata  in  CHANNELS*LANES*8  coef RAM read word.

## Operation
- Decode match requires insn[6:0]=7'b0001011 and insn[31:25]=7'b0100000. Other instructions are ignored.
- funct3 = insn[14:12] selects the operation:
  - 0 MACC: acc[c] ← sat(acc[c] + dot[c]) for every channel. rd = new acc[0].
  - 1 MACB: acc[rs1[7:0]] ← sext(rs2[ACC_W-1:0]). rd = rs2.
  - 2 RDACC: rd = sext(acc[rs1[7:0]]).
  - 3 RDACCZ: same as RDACC, but a negative value returns 0.
  - 4 CLR: all acc ← 0 and sat_flags ← 0. rd = 0.
  - 5 RDSAT: rd = zero-extended sat_flags (CHANNELS bits).
  - 6, 7: no match. The block never raises wait or ready, so picorv32 traps the instruction as illegal.
- Channel index ≥ CHANNELS: MACB has no effect; RDACC and RDACCZ return 0.
- Lane mapping: d[i] = data_rdata[8i+:8] (unsigned); w[c][i] = coef_rdata[(c*LANES+i)*8+:8] (signed).
- dot[c] = Σ_i d[i]*w[c][i].
  - Each product is 17-bit signed.
  - The sum is 17+clog2(LANES) bits, exact with no overflow.
- sat(): clamps the result to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Whenever a clamp occurs, sat_flags[c] is set (sticky).
  - Only CLR or reset clears it.
- FSM states: IDLE, FETCH, MUL, SUM, ACC, EXEC, DONE, COOL.
  - IDLE: on pcpi_valid with a match, latch op/rs1/rs2. Go to FETCH for MACC, EXEC otherwise.
  - FETCH: mem_busy=1 and addresses are driven, for exactly RD_LAT cycles.
  - MUL: register all CHANNELS*LANES products from the RAM data.
  - SUM: register dot[c] for each channel.
  - ACC: commit the saturated accumulators and flags.
  - EXEC: perform a non-MACC operation and commit.
  - DONE: pcpi_ready=1; pcpi_wr=1 for every matched operation. Next state is COOL.
  - COOL: one cycle during which pcpi_valid is ignored. Next state is IDLE.
- Abort: if pcpi_valid is low in FETCH, MUL or SUM, return to IDLE next cycle.
  - No ready pulse is issued.
  - Accumulators are unchanged.
  - A commit made in ACC or EXEC is never rolled back.
- pcpi_wait is registered: high from the cycle after acceptance through DONE, otherwise low.
- pcpi_rd holds its value until the next DONE.
- Reset values:
  - State IDLE.
  - All acc = 0 and sat_flags = 0.
  - pcpi_wr, pcpi_ready, pcpi_wait, mem_busy = 0.
  - pcpi_rd, data_addr, coef_addr = 0.

## Timing
- Cycle 0 is the first cycle where pcpi_valid and a decode match are seen in IDLE.
- MACC: mem_busy is high in cycles 1..RD_LAT. pcpi_ready is high in cycle RD_LAT+4 (cycle 5 at RD_LAT=1).
- Other operations: pcpi_ready is high in cycle 2.
- Back-to-back: the earliest next acceptance is two cycles after DONE.
- The block issues one operation at a time and never overlaps operations.
- All outputs come from registers; there are no combinational paths from PCPI inputs to outputs.

## Test plan
- Reset: assert resetn=0 mid-MACC (in SUM). Required:
  - All outputs drop to 0 asynchronously.
  - After release, RDACC of channels 0 and 1 returns 0.
- MACC, defaults:
  - Stimulus: data all 0xFF, coef ch0 all 0x7F, ch1 all 0x80.
  - ready in cycle 5, pcpi_rd=259080.
  - RDACC(1) = -261120 (0xFFFC0400).
- Saturation:
  - MACB(0, 0x7FFFFF00), then the MACC above gives rd=0x7FFFFFFF.
  - RDSAT=0x1. CLR, then RDSAT=0.
- ReLU and index range:
  - With acc1=-261120, RDACCZ(1)=0 and RDACC(1)=0xFFFC0400.
  - RDACC(5)=0. MACB(5,…) leaves all accumulators unchanged.
- Latency and abort:
  - With RD_LAT=3, ready comes in cycle 7.
  - Dropping pcpi_valid in MUL: no ready pulse, accumulators unchanged, next MACC behaves normally.
- Illegal funct3=6: pcpi_wait and pcpi_ready stay 0 for 20 cycles.

Source files
------------

// File: rtl/olimp_pcpi_vmac.sv
// PCPI vector multiply-accumulate coprocessor: uint8 x int8 dot products per channel
// feeding saturating accumulators, with bias load, ReLU readout and clear operations.
module olimp_pcpi_vmac #(
  parameter int LANES    = 8,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32,
  parameter int DATA_AW  = 17,
  parameter int COEF_AW  = 15,
  parameter int RD_LAT   = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           pcpi_valid,
  input  logic [31:0]                    pcpi_insn,
  input  logic [31:0]                    pcpi_rs1,
  input  logic [31:0]                    pcpi_rs2,
  output logic                           pcpi_wr,
  output logic [31:0]                    pcpi_rd,
  output logic                           pcpi_wait,
  output logic                           pcpi_ready,
  output logic                           mem_busy,
  output logic [DATA_AW-1:0]             data_addr,
  output logic [COEF_AW-1:0]             coef_addr,
  input  logic [LANES*8-1:0]             data_rdata,
  input  logic [CHANNELS*LANES*8-1:0]    coef_rdata
);

  localparam int DOT_W = 17 + $clog2(LANES);
  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MUL, S_SUM, S_ACC, S_EXEC, S_DONE, S_COOL
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                op_q;
  logic [7:0]                idx_q;
  logic [31:0]               rs2_q;
  logic signed [ACC_W-1:0]   acc     [CHANNELS];
  logic signed [ACC_W-1:0]   acc_nxt [CHANNELS];
  logic [CHANNELS-1:0]       sat_flags, sat_nxt;
  logic [31:0]               res;
  logic [ACC_W:0]            sat_t;
  logic signed [16:0]        prod_p1 [CHANNELS][LANES];
  logic signed [DOT_W-1:0]   dot_sum [CHANNELS];
  logic signed [DOT_W-1:0]   dot_p2  [CHANNELS];
  logic                      match, accept;
  logic                      unused_bits;

  function automatic logic signed [16:0] mul_u8s8(input logic [7:0] d, input logic [7:0] w);
    return $signed({9'b0, d}) * $signed({{9{w[7]}}, w});
  endfunction

  // Returns {clamped, value}; the extra MSB catches overflow of the signed sum.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [DOT_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign match  = (pcpi_insn[6:0] == 7'b0001011) && (pcpi_insn[31:25] == 7'b0100000) &&
                  (pcpi_insn[14:12] <= 3'd5);
  assign accept = (state == S_IDLE) && pcpi_valid && match;
  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], pcpi_rs1[31:DATA_AW]};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (pcpi_insn[14:12] == 3'd0) ? S_FETCH : S_EXEC;
      S_FETCH: if (!pcpi_valid) state_nxt = S_IDLE;
               else if (cnt == CNT_W'(RD_LAT - 1)) state_nxt = S_MUL;
      S_MUL:   state_nxt = pcpi_valid ? S_SUM : S_IDLE;
      S_SUM:   state_nxt = pcpi_valid ? S_ACC : S_IDLE;
      S_ACC:   state_nxt = S_DONE;
      S_EXEC:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_COOL;
      S_COOL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      dot_sum[c] = '0;
      for (int i = 0; i < LANES; i++) dot_sum[c] = dot_sum[c] + DOT_W'(prod_p1[c][i]);
    end
  end

  // Commit values for ACC (MACC) and EXEC (all other operations)
  always_comb begin
    acc_nxt = acc;
    sat_nxt = sat_flags;
    res     = pcpi_rd;
    sat_t   = '0;
    if (state == S_ACC) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sat_t      = sat_add(acc[c], dot_p2[c]);
        acc_nxt[c] = sat_t[ACC_W-1:0];
        if (sat_t[ACC_W]) sat_nxt[c] = 1'b1;
      end
      res = 32'(acc_nxt[0]);
    end else if (state == S_EXEC) begin
      res = '0;
      case (op_q)
        3'd1: begin
          res = rs2_q;
          for (int c = 0; c < CHANNELS; c++)
            if (idx_q == 8'(c)) acc_nxt[c] = rs2_q[ACC_W-1:0];
        end
        3'd2, 3'd3: begin
          for (int c = 0; c < CHANNELS; c++)
            if (idx_q == 8'(c))
              res = (op_q == 3'd3 && acc[c][ACC_W-1]) ? 32'd0 : 32'(acc[c]);
        end
        3'd4: begin
          for (int c = 0; c < CHANNELS; c++) acc_nxt[c] = '0;
          sat_nxt = '0;
        end
        3'd5: res = 32'(sat_flags);
        default: res = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      idx_q      <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      mem_busy   <= 1'b0;
      pcpi_rd    <= '0;
      data_addr  <= '0;
      coef_addr  <= '0;
      sat_flags  <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= (state == S_FETCH) ? cnt + CNT_W'(1) : '0;
      pcpi_wait  <= (state_nxt != S_IDLE) && (state_nxt != S_COOL);
      pcpi_ready <= (state_nxt == S_DONE);
      pcpi_wr    <= (state_nxt == S_DONE);
      mem_busy   <= (state_nxt == S_FETCH);
      if (accept) begin
        op_q      <= pcpi_insn[14:12];
        idx_q     <= pcpi_rs1[7:0];
        data_addr <= pcpi_rs1[DATA_AW-1:0];
        coef_addr <= pcpi_rs2[COEF_AW-1:0];
      end
      if (state == S_ACC || state == S_EXEC) begin
        pcpi_rd   <= res;
        sat_flags <= sat_nxt;
        for (int c = 0; c < CHANNELS; c++) acc[c] <= acc_nxt[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rs2_q <= pcpi_rs2;
    // MUL -> p1: per-lane products from the RAM words
    if (state == S_MUL)
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < LANES; i++)
          prod_p1[c][i] <= mul_u8s8(data_rdata[8*i +: 8], coef_rdata[(c*LANES+i)*8 +: 8]);
    // SUM -> p2: per-channel dot products
    if (state == S_SUM)
      for (int c = 0; c < CHANNELS; c++) dot_p2[c] <= dot_sum[c];
  end

endmodule

// File: tb/tb_olimp_pcpi_vmac.sv
// Directed bench for olimp_pcpi_vmac: a driver issues PCPI operations and queues the
// expected result; a monitor checks pcpi_rd/pcpi_wr on every ready pulse.
module tb_olimp_pcpi_vmac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         pcpi_valid, valid3;
  logic [31:0]  insn, rs1, rs2;
  logic         pcpi_wr, pcpi_wait, pcpi_ready, mem_busy;
  logic [31:0]  pcpi_rd;
  logic [16:0]  data_addr;
  logic [14:0]  coef_addr;
  logic [63:0]  data_rdata;
  logic [127:0] coef_rdata;
  logic         pcpi_wr3, pcpi_wait3, pcpi_ready3, mem_busy3;
  logic [31:0]  pcpi_rd3;
  logic [16:0]  data_addr3;
  logic [14:0]  coef_addr3;
  logic [63:0]  data_rdata3, d3a, d3b;
  logic [127:0] coef_rdata3, c3a, c3b;

  olimp_pcpi_vmac u_dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .mem_busy(mem_busy),
    .data_addr(data_addr), .coef_addr(coef_addr),
    .data_rdata(data_rdata), .coef_rdata(coef_rdata)
  );

  olimp_pcpi_vmac #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .pcpi_valid(valid3), .pcpi_insn(insn),
    .pcpi_rs1(rs1), .pcpi_rs2(rs2), .pcpi_wr(pcpi_wr3), .pcpi_rd(pcpi_rd3),
    .pcpi_wait(pcpi_wait3), .pcpi_ready(pcpi_ready3), .mem_busy(mem_busy3),
    .data_addr(data_addr3), .coef_addr(coef_addr3),
    .data_rdata(data_rdata3), .coef_rdata(coef_rdata3)
  );

  // Two-entry RAM images; the bus reads zero whenever the block does not own it.
  function automatic logic [63:0] dmem(input logic busy, input logic [16:0] a);
    if (!busy) return 64'h0;
    return a[0] ? 64'h0807060504030201 : {8{8'hFF}};
  endfunction

  function automatic logic [127:0] cmem(input logic busy, input logic [14:0] a);
    if (!busy) return 128'h0;
    return a[0] ? {{8{8'hFF}}, {8{8'h01}}} : {{8{8'h80}}, {8{8'h7F}}};
  endfunction

  always @(posedge clk) begin
    data_rdata  <= dmem(mem_busy, data_addr);
    coef_rdata  <= cmem(mem_busy, coef_addr);
    d3a         <= dmem(mem_busy3, data_addr3);
    d3b         <= d3a;
    data_rdata3 <= d3b;
    c3a         <= cmem(mem_busy3, coef_addr3);
    c3b         <= c3a;
    coef_rdata3 <= c3b;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
  endfunction

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (resetn === 1'b1 && pcpi_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: rd=%0h with no pending operation", pcpi_rd);
      end else begin
        e = exp_q.pop_front();
        chk("rd", pcpi_rd, e);
        chk("wr", {31'b0, pcpi_wr}, 32'd1);
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_rd);
    int lat, busy_n, wait_n, exp_lat;
    exp_lat = (f3 == 3'd0) ? 5 : 2;
    @(posedge clk); #1;
    insn = mk(f3, 7'b0100000); rs1 = a; rs2 = b; pcpi_valid = 1'b1;
    exp_q.push_back(exp_rd);
    lat = 0; busy_n = 0; wait_n = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      busy_n += int'(mem_busy);
      wait_n += int'(pcpi_wait);
    end while (!pcpi_ready && lat < 30);
    chk($sformatf("%s_lat", nm), lat, exp_lat);
    chk($sformatf("%s_busy", nm), busy_n, (f3 == 3'd0) ? 1 : 0);
    chk($sformatf("%s_wait", nm), wait_n, exp_lat);
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, busy_n, rdy_n, wait_n;
    logic [31:0] bad [2];
    resetn = 1'b0; pcpi_valid = 1'b0; valid3 = 1'b0;
    insn = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, pcpi_ready}, 0);
    chk("reset_wait",  {31'b0, pcpi_wait}, 0);
    chk("reset_busy",  {31'b0, mem_busy}, 0);
    chk("reset_rd",    pcpi_rd, 0);
    resetn = 1'b1;

    // RD_LAT=3 instance: ready at cycle 7, busy for 3 cycles
    @(posedge clk); #1;
    insn = mk(3'd0, 7'b0100000); rs1 = 0; rs2 = 0; valid3 = 1'b1;
    lat = 0; busy_n = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      busy_n += int'(mem_busy3);
    end while (!pcpi_ready3 && lat < 30);
    chk("lat3_ready", lat, 7);
    chk("lat3_busy", busy_n, 3);
    chk("lat3_rd", pcpi_rd3, 32'd259080);
    valid3 = 1'b0;
    @(posedge clk); #1;

    run_op("macc_ff",     3'd0, 0, 0, 32'd259080);
    run_op("rdacc1",      3'd2, 1, 0, 32'hFFFC0400);
    run_op("rdaccz1",     3'd3, 1, 0, 32'd0);
    run_op("rdacc0",      3'd2, 0, 0, 32'd259080);
    run_op("rdaccz0",     3'd3, 0, 0, 32'd259080);
    run_op("rdacc5",      3'd2, 5, 0, 32'd0);
    run_op("macb5",       3'd1, 5, 32'h1234, 32'h1234);
    run_op("rdacc0_b",    3'd2, 0, 0, 32'd259080);
    run_op("rdacc1_b",    3'd2, 1, 0, 32'hFFFC0400);
    run_op("macc_ramp",   3'd0, 1, 1, 32'd259116);
    run_op("rdacc1_ramp", 3'd2, 1, 0, 32'hFFFC03DC);

    // Abort in MUL
    @(posedge clk); #1;
    insn = mk(3'd0, 7'b0100000); rs1 = 1; rs2 = 1; pcpi_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pcpi_valid = 1'b0;
    rdy_n = 0; wait_n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      rdy_n  += int'(pcpi_ready);
      wait_n += int'(pcpi_wait);
    end
    chk("abort_ready", rdy_n, 0);
    chk("abort_wait", wait_n, 0);
    run_op("rdacc0_abort",     3'd2, 0, 0, 32'd259116);
    run_op("macc_after_abort", 3'd0, 1, 1, 32'd259152);

    // Asynchronous reset while in SUM
    @(posedge clk); #1;
    insn = mk(3'd0, 7'b0100000); rs1 = 1; rs2 = 1; pcpi_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_wait", {31'b0, pcpi_wait}, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_wait",  {31'b0, pcpi_wait}, 0);
    chk("rst_rd",    pcpi_rd, 0);
    chk("rst_daddr", {15'b0, data_addr}, 0);
    chk("rst_caddr", {17'b0, coef_addr}, 0);
    chk("rst_wr",    {31'b0, pcpi_wr}, 0);
    pcpi_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    run_op("rdacc0_rst", 3'd2, 0, 0, 32'd0);
    run_op("rdacc1_rst", 3'd2, 1, 0, 32'd0);

    run_op("macb0_big",   3'd1, 0, 32'h7FFFFF00, 32'h7FFFFF00);
    run_op("macc_sat",    3'd0, 0, 0, 32'h7FFFFFFF);
    run_op("rdsat1",      3'd5, 0, 0, 32'd1);
    run_op("clr",         3'd4, 0, 0, 32'd0);
    run_op("rdsat0",      3'd5, 0, 0, 32'd0);
    run_op("rdacc1_clr",  3'd2, 1, 0, 32'd0);
    run_op("macb1_neg",   3'd1, 1, 32'h80000100, 32'h80000100);
    run_op("macc_negsat", 3'd0, 0, 0, 32'd259080);
    run_op("rdacc1_neg",  3'd2, 1, 0, 32'h80000000);
    run_op("rdsat2",      3'd5, 0, 0, 32'd2);

    // Instructions that must not be claimed
    bad[0] = mk(3'd6, 7'b0100000);
    bad[1] = mk(3'd0, 7'b0000000);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      insn = bad[k]; rs1 = 0; rs2 = 0; pcpi_valid = 1'b1;
      rdy_n = 0; wait_n = 0;
      repeat (20) begin
        @(posedge clk); #1;
        rdy_n  += int'(pcpi_ready);
        wait_n += int'(pcpi_wait);
      end
      chk($sformatf("illegal%0d_ready", k), rdy_n, 0);
      chk($sformatf("illegal%0d_wait", k), wait_n, 0);
      pcpi_valid = 1'b0;
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
